// File: rtl/miter_divergence_monitor.sv
// Lockstep divergence monitor for the two-core SCARV miter: latches the first
// externally observable P1/P2 difference with a cause code and cycle stamp.
// Optional macro MITER_MON_TRACE_CMP_EN swaps the cycle-exact trace compare
// for an in-order compare through two skew-tolerant trace FIFOs.
module miter_divergence_monitor #(
  parameter int XL            = 31,
  parameter int WARMUP_CYCLES = 0,
  parameter int CNT_W         = 32,
  parameter int TRC_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             p1_imem_req,
  input  logic             p2_imem_req,
  input  logic [XL:0]      p1_imem_addr,
  input  logic [XL:0]      p2_imem_addr,
  input  logic             p1_dmem_req,
  input  logic             p2_dmem_req,
  input  logic             p1_dmem_wen,
  input  logic             p2_dmem_wen,
  input  logic [3:0]       p1_dmem_strb,
  input  logic [3:0]       p2_dmem_strb,
  input  logic [XL:0]      p1_dmem_addr,
  input  logic [XL:0]      p2_dmem_addr,
  input  logic             p1_trs_valid,
  input  logic             p2_trs_valid,
  input  logic [XL:0]      p1_trs_pc,
  input  logic [XL:0]      p2_trs_pc,
  output logic             armed,
  output logic             diverged,
  output logic [2:0]       div_cause,
  output logic [CNT_W-1:0] div_cycle,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DIVERGED} state_e;

  localparam int WC_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);

  if (TRC_DEPTH < 2 || (TRC_DEPTH & (TRC_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRC_DEPTH must be a power of two, at least 2");
  end

  state_e           state_q, state_d;
  logic [WC_W-1:0]  warm_q, warm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dcyc_q, dcyc_d;
  logic [2:0]       cause_q, cause_d, cause_now;
  logic             chk;
  logic             c1, c2, c3, c4, c5, c6;

  assign chk = (state_q == CHECK);

  assign c1 = (p1_imem_req != p2_imem_req) ||
              (p1_imem_req && p2_imem_req && (p1_imem_addr != p2_imem_addr));
  assign c2 = (p1_dmem_req != p2_dmem_req) ||
              (p1_dmem_req && p2_dmem_req &&
               ((p1_dmem_wen != p2_dmem_wen) || (p1_dmem_strb != p2_dmem_strb)));
  assign c3 = p1_dmem_req && p2_dmem_req && (p1_dmem_addr != p2_dmem_addr);

`ifdef MITER_MON_TRACE_CMP_EN
  localparam int PW = $clog2(TRC_DEPTH);

  // FIFOs only move in CHECK; they are empty on entry because the only way
  // back into CHECK is through rst.
  logic [XL:0]           mem_q [2][TRC_DEPTH];
  logic [1:0][PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [1:0][PW:0]      occ_q, occ_d;
  logic [1:0][XL:0]      push_pc;
  logic [1:0]            push, full, nonempty, wr_en;
  logic                  pop;

  assign push_pc = {p2_trs_pc, p1_trs_pc};
  assign push    = {p2_trs_valid, p1_trs_valid} & {2{chk}};
  assign pop     = chk && nonempty[0] && nonempty[1];
  assign c4      = 1'b0;
  assign c5      = pop && (mem_q[0][rd_q[0]] != mem_q[1][rd_q[1]]);
  assign c6      = |(push & full & {2{~pop}});

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    occ_d    = occ_q;
    wr_en    = '0;
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]     = (occ_q[i] == (PW+1)'(TRC_DEPTH));
      nonempty[i] = (occ_q[i] != '0);
      wr_en[i]    = push[i] && (!full[i] || pop);
      if (wr_en[i]) wr_d[i] = wr_q[i] + 1'b1;
      if (pop)      rd_d[i] = rd_q[i] + 1'b1;
      occ_d[i] = occ_q[i] + (PW+1)'(wr_en[i]) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // NOTE: trace storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) mem_q[i][wr_q[i]] <= push_pc[i];
    end
  end
`else
  assign c4 = (p1_trs_valid != p2_trs_valid) ||
              (p1_trs_valid && p2_trs_valid && (p1_trs_pc != p2_trs_pc));
  assign c5 = 1'b0;
  assign c6 = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cause_now = 3'd0;
    if      (c1) cause_now = 3'd1;
    else if (c2) cause_now = 3'd2;
    else if (c3) cause_now = 3'd3;
    else if (c4) cause_now = 3'd4;
    else if (c5) cause_now = 3'd5;
    else if (c6) cause_now = 3'd6;
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      IDLE: if (arm) begin
        state_d = (WARMUP_CYCLES == 0) ? CHECK : WARMUP;
        warm_d  = '0;
      end
      WARMUP: begin
        if (warm_q == WC_W'(WARMUP_CYCLES - 1)) state_d = CHECK;
        else                                    warm_d  = warm_q + 1'b1;
      end
      CHECK:    if (cause_now != 3'd0) state_d = DIVERGED;
      DIVERGED: state_d = DIVERGED;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    dcyc_d  = dcyc_q;
    cause_d = cause_q;
    if (chk) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (cause_now != 3'd0) begin
        dcyc_d  = cnt_q;
        cause_d = cause_now;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      warm_q  <= '0;
      cnt_q   <= '0;
      dcyc_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      dcyc_q  <= dcyc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    armed    = (state_q == WARMUP) || (state_q == CHECK);
    diverged = (state_q == DIVERGED);
  end

  assign div_cause = cause_q;
  assign div_cycle = dcyc_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_miter_divergence_monitor.sv
// Scoreboard bench for miter_divergence_monitor: three instances (no warm-up,
// five-cycle warm-up, 3-bit counter) share stimulus; expectations are queued per cycle.
module tb_miter_divergence_monitor;

  localparam int XL  = 31;
  localparam int TRC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm;
  logic        p1_imem_req, p2_imem_req, p1_dmem_req, p2_dmem_req;
  logic        p1_dmem_wen, p2_dmem_wen, p1_trs_valid, p2_trs_valid;
  logic [3:0]  p1_dmem_strb, p2_dmem_strb;
  logic [XL:0] p1_imem_addr, p2_imem_addr, p1_dmem_addr, p2_dmem_addr;
  logic [XL:0] p1_trs_pc, p2_trs_pc;

  logic        a0, d0, a5, d5, as, ds;
  logic [2:0]  k0, k5, ks;
  logic [31:0] y0, n0, y5, n5;
  logic [2:0]  ys, ns;

  typedef struct packed {
    logic        armed;
    logic        diverged;
    logic [2:0]  cause;
    logic [31:0] dcyc;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, want;
  int   errors = 0;
  int   checks = 0;

  miter_divergence_monitor #(.XL(XL), .WARMUP_CYCLES(0), .CNT_W(32), .TRC_DEPTH(TRC)) dut0 (
    .clk(clk), .rst(rst), .arm(arm),
    .p1_imem_req(p1_imem_req), .p2_imem_req(p2_imem_req),
    .p1_imem_addr(p1_imem_addr), .p2_imem_addr(p2_imem_addr),
    .p1_dmem_req(p1_dmem_req), .p2_dmem_req(p2_dmem_req),
    .p1_dmem_wen(p1_dmem_wen), .p2_dmem_wen(p2_dmem_wen),
    .p1_dmem_strb(p1_dmem_strb), .p2_dmem_strb(p2_dmem_strb),
    .p1_dmem_addr(p1_dmem_addr), .p2_dmem_addr(p2_dmem_addr),
    .p1_trs_valid(p1_trs_valid), .p2_trs_valid(p2_trs_valid),
    .p1_trs_pc(p1_trs_pc), .p2_trs_pc(p2_trs_pc),
    .armed(a0), .diverged(d0), .div_cause(k0), .div_cycle(y0), .cycle_cnt(n0));

  miter_divergence_monitor #(.XL(XL), .WARMUP_CYCLES(5), .CNT_W(32), .TRC_DEPTH(TRC)) dut5 (
    .clk(clk), .rst(rst), .arm(arm),
    .p1_imem_req(p1_imem_req), .p2_imem_req(p2_imem_req),
    .p1_imem_addr(p1_imem_addr), .p2_imem_addr(p2_imem_addr),
    .p1_dmem_req(p1_dmem_req), .p2_dmem_req(p2_dmem_req),
    .p1_dmem_wen(p1_dmem_wen), .p2_dmem_wen(p2_dmem_wen),
    .p1_dmem_strb(p1_dmem_strb), .p2_dmem_strb(p2_dmem_strb),
    .p1_dmem_addr(p1_dmem_addr), .p2_dmem_addr(p2_dmem_addr),
    .p1_trs_valid(p1_trs_valid), .p2_trs_valid(p2_trs_valid),
    .p1_trs_pc(p1_trs_pc), .p2_trs_pc(p2_trs_pc),
    .armed(a5), .diverged(d5), .div_cause(k5), .div_cycle(y5), .cycle_cnt(n5));

  miter_divergence_monitor #(.XL(XL), .WARMUP_CYCLES(0), .CNT_W(3), .TRC_DEPTH(TRC)) dut_s (
    .clk(clk), .rst(rst), .arm(arm),
    .p1_imem_req(p1_imem_req), .p2_imem_req(p2_imem_req),
    .p1_imem_addr(p1_imem_addr), .p2_imem_addr(p2_imem_addr),
    .p1_dmem_req(p1_dmem_req), .p2_dmem_req(p2_dmem_req),
    .p1_dmem_wen(p1_dmem_wen), .p2_dmem_wen(p2_dmem_wen),
    .p1_dmem_strb(p1_dmem_strb), .p2_dmem_strb(p2_dmem_strb),
    .p1_dmem_addr(p1_dmem_addr), .p2_dmem_addr(p2_dmem_addr),
    .p1_trs_valid(p1_trs_valid), .p2_trs_valid(p2_trs_valid),
    .p1_trs_pc(p1_trs_pc), .p2_trs_pc(p2_trs_pc),
    .armed(as), .diverged(ds), .div_cause(ks), .div_cycle(ys), .cycle_cnt(ns));

  function automatic obs_t mk(logic a, logic d, logic [2:0] c, int unsigned y, int unsigned n);
    mk = '{armed: a, diverged: d, cause: c, dcyc: y, cnt: n};
  endfunction

  function automatic obs_t obs0(); obs0 = '{a0, d0, k0, y0, n0}; endfunction
  function automatic obs_t obs5(); obs5 = '{a5, d5, k5, y5, n5}; endfunction
  function automatic obs_t obss(); obss = '{as, ds, ks, {29'd0, ys}, {29'd0, ns}}; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Identical random activity on both cores.
  task automatic drive_same();
    p1_imem_req  = 1'($urandom);  p1_imem_addr = $urandom;
    p1_dmem_req  = 1'($urandom);  p1_dmem_wen  = 1'($urandom);
    p1_dmem_strb = 4'($urandom);  p1_dmem_addr = $urandom;
    p1_trs_valid = 1'($urandom);  p1_trs_pc    = $urandom;
    p2_imem_req  = p1_imem_req;   p2_imem_addr = p1_imem_addr;
    p2_dmem_req  = p1_dmem_req;   p2_dmem_wen  = p1_dmem_wen;
    p2_dmem_strb = p1_dmem_strb;  p2_dmem_addr = p1_dmem_addr;
    p2_trs_valid = p1_trs_valid;  p2_trs_pc    = p1_trs_pc;
  endtask

  task automatic drive_diff();
    drive_same();
    p2_imem_req  = ~p1_imem_req;  p2_imem_addr = ~p1_imem_addr;
    p2_dmem_req  = ~p1_dmem_req;  p2_dmem_strb = ~p1_dmem_strb;
    p2_dmem_addr = ~p1_dmem_addr; p2_trs_valid = ~p1_trs_valid;
  endtask

  task automatic apply_reset();
    rst = 1'b1; arm = 1'b0; drive_same();
    tick();
    rst = 1'b0;
  endtask

  // Arms the block (arm cycle) and checks the W=0 instance armed afterwards.
  task automatic arm_dut0(string tag);
    arm = 1'b1; drive_same();
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    tick(); arm = 1'b0;
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL %s_arm got=%p want=%p", tag, got, want); end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; drive_diff();
    tick();
    arm = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 0, 0, 0));
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_dut0 got=%p want=%p", got, want); end
    got = obs5(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_dut5 got=%p want=%p", got, want); end
    got = obss(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_duts got=%p want=%p", got, want); end
    rst = 1'b0; arm = 1'b0;
  endtask

  task automatic test_identical();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      drive_same();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL idle_c%0d got=%p want=%p", c, got, want); end
    end
    arm_dut0("identical");
    for (int k = 0; k < 100; k++) begin
      drive_same();
      arm = (k == 50);
      exp_q.push_back(mk(1, 0, 0, 0, k + 1));
      tick(); arm = 1'b0;
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL identical_k%0d got=%p want=%p", k, got, want); end
    end
  endtask

  task automatic test_dmem_addr();
    apply_reset();
    arm_dut0("dmem");
    for (int k = 0; k < 8; k++) begin
      drive_same();
      p1_dmem_req = 1'b1; p2_dmem_req = 1'b1;
      p1_dmem_addr = 32'h8000_0100;
      p2_dmem_addr = (k == 7) ? 32'h8000_0104 : 32'h8000_0100;
      exp_q.push_back((k == 7) ? mk(0, 1, 3, 7, 8) : mk(1, 0, 0, 0, k + 1));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL dmem_k%0d got=%p want=%p", k, got, want); end
    end
    for (int j = 0; j < 5; j++) begin
      drive_diff();
      arm = (j == 1);
      exp_q.push_back(mk(0, 1, 3, 7, 8));
      tick(); arm = 1'b0;
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL frozen_j%0d got=%p want=%p", j, got, want); end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    arm_dut0("prio1");
    for (int k = 0; k < 4; k++) begin
      drive_same();
      if (k == 3) begin
        p1_imem_req = 1'b1; p2_imem_req = 1'b0;
        p1_dmem_req = 1'b1; p2_dmem_req = 1'b1;
        p1_dmem_strb = 4'hF; p2_dmem_strb = 4'h3;
      end
      exp_q.push_back((k == 3) ? mk(0, 1, 1, 3, 4) : mk(1, 0, 0, 0, k + 1));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL prio1_k%0d got=%p want=%p", k, got, want); end
    end
    // strb and address both differ: the write-shape cause wins over the address cause
    apply_reset();
    arm_dut0("prio2");
    drive_same();
    p1_dmem_req = 1'b1; p2_dmem_req = 1'b1;
    p1_dmem_strb = 4'h1; p2_dmem_strb = 4'h2;
    p1_dmem_addr = 32'h10; p2_dmem_addr = 32'h20;
    exp_q.push_back(mk(0, 1, 2, 0, 1));
    tick();
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL prio2 got=%p want=%p", got, want); end
    // address differs together with a trace difference: address cause wins
    apply_reset();
    arm_dut0("prio3");
    drive_same();
    p1_dmem_req = 1'b1; p2_dmem_req = 1'b1;
    p1_dmem_addr = 32'h40; p2_dmem_addr = 32'h44;
    p1_trs_valid = 1'b1; p2_trs_valid = 1'b0;
    exp_q.push_back(mk(0, 1, 3, 0, 1));
    tick();
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL prio3 got=%p want=%p", got, want); end
  endtask

  task automatic test_warmup();
    apply_reset();
    arm = 1'b1; drive_same();
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    tick(); arm = 1'b0;
    got = obs5(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL warm_arm got=%p want=%p", got, want); end
    for (int j = 1; j <= 8; j++) begin
      drive_same();
      arm = (j == 2);
      p1_imem_req = 1'b1; p2_imem_req = 1'b1;
      if (j == 3 || j == 8) p2_imem_addr = p1_imem_addr ^ 32'h4;
      if (j == 8)      exp_q.push_back(mk(0, 1, 1, 2, 3));
      else if (j <= 5) exp_q.push_back(mk(1, 0, 0, 0, 0));
      else             exp_q.push_back(mk(1, 0, 0, 0, j - 5));
      tick(); arm = 1'b0;
      got = obs5(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL warm_j%0d got=%p want=%p", j, got, want); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    arm = 1'b1; drive_same();
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    tick(); arm = 1'b0;
    got = obss(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL sat_arm got=%p want=%p", got, want); end
    for (int k = 0; k <= 12; k++) begin
      drive_same();
      if (k == 12) begin p1_imem_req = 1'b1; p2_imem_req = 1'b0; end
      exp_q.push_back((k == 12) ? mk(0, 1, 1, 7, 7) : mk(1, 0, 0, 0, (k + 1 > 7) ? 7 : k + 1));
      tick();
      got = obss(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL sat_k%0d got=%p want=%p", k, got, want); end
    end
  endtask

`ifdef MITER_MON_TRACE_CMP_EN
  task automatic test_trace();
    int skews[2] = '{2, TRC - 1};
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      arm_dut0("skew");
      for (int k = 0; k < 15; k++) begin
        drive_same();
        p1_trs_valid = (k < 6);
        p1_trs_pc    = 32'h8000_0000 + 32'(4 * k);
        p2_trs_valid = (k >= skews[s]) && (k < 6 + skews[s]);
        p2_trs_pc    = 32'h8000_0000 + 32'(4 * (k - skews[s]));
        exp_q.push_back(mk(1, 0, 0, 0, k + 1));
        tick();
        got = obs0(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL skew%0d_k%0d got=%p want=%p", skews[s], k, got, want);
        end
      end
    end
    apply_reset();
    arm_dut0("ovf");
    for (int k = 0; k <= TRC; k++) begin
      drive_same();
      p1_trs_valid = 1'b1; p1_trs_pc = 32'h100 + 32'(4 * k);
      p2_trs_valid = 1'b0;
      exp_q.push_back((k == TRC) ? mk(0, 1, 6, TRC, TRC + 1) : mk(1, 0, 0, 0, k + 1));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ovf_k%0d got=%p want=%p", k, got, want); end
    end
    apply_reset();
    arm_dut0("pc");
    for (int k = 0; k < 4; k++) begin
      drive_same();
      p1_trs_valid = 1'b1; p1_trs_pc = 32'h200 + 32'(4 * k);
      p2_trs_valid = 1'b1; p2_trs_pc = (k == 2) ? 32'h2F0 : p1_trs_pc;
      exp_q.push_back((k == 3) ? mk(0, 1, 5, 3, 4) : mk(1, 0, 0, 0, k + 1));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pc_k%0d got=%p want=%p", k, got, want); end
    end
  endtask
`else
  task automatic test_trace();
    apply_reset();
    arm_dut0("trsv");
    drive_same();
    p1_trs_valid = 1'b1; p2_trs_valid = 1'b0;
    exp_q.push_back(mk(0, 1, 4, 0, 1));
    tick();
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL trs_valid got=%p want=%p", got, want); end
    apply_reset();
    arm_dut0("trspc");
    for (int k = 0; k < 3; k++) begin
      drive_same();
      p1_trs_valid = 1'b1; p1_trs_pc = 32'h200 + 32'(4 * k);
      p2_trs_valid = 1'b1; p2_trs_pc = (k == 2) ? 32'h2F0 : p1_trs_pc;
      exp_q.push_back((k == 2) ? mk(0, 1, 4, 2, 3) : mk(1, 0, 0, 0, k + 1));
      tick();
      got = obs0(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL trs_pc_k%0d got=%p want=%p", k, got, want); end
    end
  endtask
`endif

  task automatic test_rst_mid();
    apply_reset();
    arm_dut0("rstdiv");
    drive_diff();
    exp_q.push_back(mk(0, 1, 1, 0, 1));
    tick();
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rst_pre got=%p want=%p", got, want); end
    rst = 1'b1; drive_diff();
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    tick(); rst = 1'b0;
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rst_from_div got=%p want=%p", got, want); end
    arm_dut0("rstchk");
    for (int k = 0; k < 3; k++) begin drive_same(); tick(); end
    rst = 1'b1; drive_same();
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    tick(); rst = 1'b0;
    got = obs0(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rst_from_check got=%p want=%p", got, want); end
    got = obs5(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rst_from_warmup got=%p want=%p", got, want); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identical();
    test_dmem_addr();
    test_priority();
    test_warmup();
    test_saturation();
    test_trace();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
